// File: rtl/tff_step_ctrl.sv
// Run controller for a WIDTH-bit up/down counter built from toggle cells.
// Sequences T inputs one step per cycle, with pause, clear, done and wrap status.
module tff_step_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [SW-1:0]    steps,
    input  logic             hold,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e          state;
    logic            dir_q;
    logic [SW-1:0]   remaining;
    logic            step;
    logic            at_edge;
    logic [WIDTH-1:0] t;

    assign step = (state == StRun) && !hold;

    // Wrap point: all ones when counting up, all zeros when counting down.
    assign at_edge = dir_q ? (&count) : ~(|count);

    // Toggle enables: a bit flips when every lower bit sits at the carry/borrow value.
    always_comb begin
        logic carry;
        t     = '0;
        carry = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t[i]  = step & carry;
            carry = carry & (dir_q ? count[i] : ~count[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            count     <= '0;
            remaining <= '0;
            dir_q     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            done  <= 1'b0;
            wrap  <= step & at_edge;
            count <= count ^ t;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        dir_q     <= dir;
                        remaining <= steps;
                        if (steps != '0) begin
                            state <= StRun;
                            busy  <= 1'b1;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end else if (clr) begin
                        count <= '0;
                    end
                end
                StRun: begin
                    if (hold) begin
                        state <= StPause;
                    end else begin
                        remaining <= remaining - 1'b1;
                        if (remaining == SW'(1)) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                StPause: begin
                    // Resuming takes one edge with no step.
                    if (!hold) state <= StRun;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_step_ctrl.sv
// Directed self-checking bench for tff_step_ctrl.
module tb_tff_step_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b1;
    logic [7:0] steps = '0;
    logic       hold = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    tff_step_ctrl #(.WIDTH(4), .SW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .steps (steps),
        .hold  (hold),
        .clr   (clr),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and wait (bounded) for completion; used to set up counts.
    task automatic run_steps(input logic d, input logic [7:0] n);
        bit seen = 0;
        start = 1'b1; dir = d; steps = n;
        tick();
        start = 1'b0;
        if (done) seen = 1;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL run_steps_timeout: done=%0b required 1", done);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({count, busy, done, wrap} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got %b required 0000000", {count, busy, done, wrap});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_up_run();
        start = 1'b1; dir = 1'b1; steps = 8'd5;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL up_e0: busy=%b count=%0d required busy=1 count=0", busy, count);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (count !== 4'(k) || busy !== (k < 5) || done !== (k == 5) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL up_step%0d: count=%0d busy=%b done=%b wrap=%b required %0d %b %b 0",
                         k, count, busy, done, wrap, k, k < 5, k == 5);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd5) begin
            errors++;
            $display("FAIL up_after: done=%b busy=%b count=%0d required 0 0 5", done, busy, count);
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_c [3] = '{4'd15, 4'd14, 4'd13};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL clr_idle: count=%0d required 0", count);
        end
        start = 1'b1; dir = 1'b0; steps = 8'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (count !== exp_c[k] || wrap !== (k == 0) || done !== (k == 2)) begin
                errors++;
                $display("FAIL down_step%0d: count=%0d wrap=%b done=%b required %0d %b %b",
                         k + 1, count, wrap, done, exp_c[k], k == 0, k == 2);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_after: done=%b wrap=%b required 0 0", done, wrap);
        end
    endtask

    task automatic test_zero_steps();
        // 13 -> clear -> up 7 gives 7.
        clr = 1'b1; tick(); clr = 1'b0;
        run_steps(1'b1, 8'd7);
        start = 1'b1; dir = 1'b1; steps = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd7) begin
            errors++;
            $display("FAIL zero_e0: done=%b busy=%b count=%0d required 1 0 7", done, busy, count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd7) begin
            errors++;
            $display("FAIL zero_after: done=%b busy=%b count=%0d required 0 0 7", done, busy, count);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_c [8] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4};
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; dir = 1'b1; steps = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            hold = (k >= 3 && k <= 5);
            tick();
            checks++;
            if (count !== exp_c[k-1] || busy !== (k < 8) || done !== (k == 8)) begin
                errors++;
                $display("FAIL hold_e%0d: count=%0d busy=%b done=%b required %0d %b %b",
                         k, count, busy, done, exp_c[k-1], k < 8, k == 8);
            end
        end
        hold = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        // count is 4 here.
        start = 1'b1; dir = 1'b1; steps = 8'd3;
        tick();
        clr = 1'b1; dir = 1'b0; steps = 8'd99;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (count !== 4'(4 + k) || done !== (k == 3)) begin
                errors++;
                $display("FAIL ign_run%0d: count=%0d done=%b required %0d %b",
                         k, count, done, 4 + k, k == 3);
            end
        end
        tick();
        start = 1'b0; clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd7) begin
            errors++;
            $display("FAIL ign_done: busy=%b done=%b count=%0d required 0 0 7", busy, done, count);
        end
        run_steps(1'b1, 8'd2);
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL ign_setup9: count=%0d required 9", count);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL clr_from9: count=%0d required 0", count);
        end
        run_steps(1'b1, 8'd3);
        start = 1'b1; clr = 1'b1; dir = 1'b1; steps = 8'd2;
        tick();
        start = 1'b0; clr = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 4'd3) begin
            errors++;
            $display("FAIL start_clr: busy=%b count=%0d required 1 3", busy, count);
        end
        tick(); tick();
        checks++;
        if (count !== 4'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_clr_end: count=%0d done=%b required 5 1", count, done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit saw_done = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; dir = 1'b1; steps = 8'd5;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d busy=%b done=%b required 0 0 0", count, busy, done);
        end
        tick();
        #2 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL async_no_done: done/busy=1 required 0");
        end
        start = 1'b1; dir = 1'b1; steps = 8'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (count !== 4'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL async_restart: count=%0d done=%b required 2 1", count, done);
        end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_wrap();
        test_zero_steps();
        test_hold();
        test_ignored();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
